// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and write-back entry type for the register-file write side
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO buffering long-latency write-back results
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  wb_entry_t mem [DEPTH];
  always_comb begin
    empty = wptr == rptr;
    full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_push = push && !full;
    do_pop = pop && !empty;
    head = mem[rptr[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: merges ALU and buffered slow results onto the register file write port
module rf_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_alu_we,
  input  logic [ADDR_W-1:0] i_alu_waddr,
  input  logic [DATA_W-1:0] i_alu_wdata,
  input  logic              i_slow_valid,
  output logic              o_slow_ready,
  input  logic [ADDR_W-1:0] i_slow_waddr,
  input  logic [DATA_W-1:0] i_slow_wdata,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_rd,
  input  logic [ADDR_W-1:0] i_qaddr1,
  input  logic [ADDR_W-1:0] i_qaddr2,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_alu_stall,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata
);
  localparam int NREG = 2 ** ADDR_W;
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  wb_entry_t slow_in, head;
  logic full, empty, pop, starving;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic [NREG-1:0] busy, set_mask, clr_mask;
  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .push (i_slow_valid),
    .din  (slow_in),
    .pop  (pop),
    .head (head),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    slow_in = {i_slow_waddr, i_slow_wdata};
    o_slow_ready = !full;
    pop = !i_alu_we && !empty;
    starving = i_alu_we && !empty;
    // saturate one past the limit so a misbehaving upstream cannot re-trigger by wraparound
    starve_nxt = !starving ? '0 : (starve_cnt == LIMIT + 1'b1) ? starve_cnt : starve_cnt + 1'b1;
    o_we = i_rst_n && (i_alu_we ? i_alu_waddr != REG_ZERO : pop && head.waddr != REG_ZERO);
    o_waddr = !i_rst_n ? REG_ZERO : i_alu_we ? i_alu_waddr : pop ? head.waddr : REG_ZERO;
    o_wdata = !i_rst_n ? '0 : i_alu_we ? i_alu_wdata : pop ? head.wdata : '0;
    set_mask = '0;
    set_mask[i_issue_rd] = i_issue_valid && i_issue_rd != REG_ZERO;
    clr_mask = '0;
    clr_mask[head.waddr] = pop;
    o_busy1 = busy[i_qaddr1];
    o_busy2 = busy[i_qaddr2];
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      busy <= '0;
      starve_cnt <= '0;
      o_alu_stall <= 1'b0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      starve_cnt <= starve_nxt;
      o_alu_stall <= starve_nxt == LIMIT;
    end
  // upstream must leave the port to the FIFO head during a stall cycle
  a_stall_idles_alu: assert property (@(posedge i_clk) disable iff (!i_rst_n) o_alu_stall |-> !i_alu_we);
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb_rf_writeback_ctrl: directed and random checks of rf_writeback_ctrl against a queue-based model
module tb_rf_writeback_ctrl;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_we, slow_valid, slow_ready, issue_valid, busy1, busy2, alu_stall, we;
  logic [4:0] alu_waddr, slow_waddr, issue_rd, qaddr1, qaddr2, waddr;
  logic [31:0] alu_wdata, slow_wdata, wdata;
  int n_checks = 0;
  int n_fails = 0;
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  bit [31:0] busy;
  int starve;
  bit last_push;

  rf_writeback_ctrl #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_we(alu_we), .i_alu_waddr(alu_waddr), .i_alu_wdata(alu_wdata),
    .i_slow_valid(slow_valid), .o_slow_ready(slow_ready),
    .i_slow_waddr(slow_waddr), .i_slow_wdata(slow_wdata),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_qaddr1(qaddr1), .i_qaddr2(qaddr2), .o_busy1(busy1), .o_busy2(busy2),
    .o_alu_stall(alu_stall), .o_we(we), .o_waddr(waddr), .o_wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_we = 0; alu_waddr = 0; alu_wdata = 0;
    slow_valid = 0; slow_waddr = 0; slow_wdata = 0;
    issue_valid = 0; issue_rd = 0; qaddr1 = 0; qaddr2 = 0;
  endtask

  task automatic set_slow(input bit v, input logic [4:0] a, input logic [31:0] d);
    slow_valid = v; slow_waddr = a; slow_wdata = d;
  endtask

  task automatic set_alu(input bit v, input logic [4:0] a, input logic [31:0] d);
    alu_we = v; alu_waddr = a; alu_wdata = d;
  endtask

  // compare outputs with the model at the falling edge, then advance the model one clock
  task automatic step();
    bit exp_ready, pop_m, exp_we;
    logic [4:0] ea;
    logic [31:0] ed;
    @(negedge clk);
    exp_ready = q.size() < DEPTH;
    pop_m = !alu_we && q.size() > 0;
    ea = alu_we ? alu_waddr : pop_m ? q[0].a : 5'd0;
    ed = alu_we ? alu_wdata : pop_m ? q[0].d : 32'd0;
    exp_we = (alu_we || pop_m) && ea != 5'd0;
    chk("slow_ready", slow_ready, exp_ready);
    chk("we", we, exp_we);
    if (exp_we) begin
      chk("waddr", waddr, ea);
      chk("wdata", wdata, ed);
    end
    chk("busy1", busy1, busy[qaddr1]);
    chk("busy2", busy2, busy[qaddr2]);
    chk("alu_stall", alu_stall, starve == LIMIT);
    last_push = slow_valid && exp_ready;
    starve = (alu_we && q.size() > 0) ? starve + 1 : 0;
    if (pop_m) begin
      busy[q[0].a] = 1'b0;
      void'(q.pop_front());
    end
    if (last_push) q.push_back('{slow_waddr, slow_wdata});
    if (issue_valid && issue_rd != 5'd0) busy[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_we", we, 0);
    chk("rst_ready", slow_ready, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_stall", alu_stall, 0);
    q.delete();
    busy = '0;
    starve = 0;
    last_push = 0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    do_reset();
    repeat (2) step();
    // reset while busy bits are set and the FIFO is full
    set_alu(1, 5'd3, 32'h11);
    issue_valid = 1; issue_rd = 5'd9; set_slow(1, 5'd9, 32'h9999);
    step();
    issue_rd = 5'd10; set_slow(1, 5'd10, 32'hAAAA);
    step();
    issue_valid = 0; set_slow(0, 0, 0); qaddr1 = 5'd9; qaddr2 = 5'd10;
    #1;
    chk("pre_rst_busy", busy1, 1);
    chk("pre_rst_full", slow_ready, 0);
    do_reset();
    qaddr1 = 5'd9; qaddr2 = 5'd10;
    repeat (3) step();
    chk("post_rst_we", we, 0);
    // single slow result with no ALU traffic
    issue_valid = 1; issue_rd = 5'd5; qaddr1 = 5'd5;
    step();
    issue_valid = 0; set_slow(1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("busy5_pending", busy1, 1);
    step();
    set_slow(0, 0, 0);
    #1;
    chk("dead_we", we, 1);
    chk("dead_waddr", waddr, 5);
    chk("dead_wdata", wdata, 32'hDEADBEEF);
    chk("busy5_still", busy1, 1);
    step();
    chk("busy5_cleared", busy1, 0);
    // starvation: ALU wins every cycle while the FIFO holds two entries
    set_alu(1, 5'd3, 32'h11);
    issue_valid = 1; issue_rd = 5'd12; set_slow(1, 5'd12, 32'hC0DE0012); qaddr1 = 5'd12; qaddr2 = 5'd13;
    step();
    issue_rd = 5'd13; set_slow(1, 5'd13, 32'hC0DE0013);
    step();
    issue_valid = 0; set_slow(0, 0, 0);
    #1;
    chk("starve_ready", slow_ready, 0);
    repeat (3) step();
    chk("stall_set", alu_stall, 1);
    set_alu(0, 0, 0);
    #1;
    chk("stall_head_we", we, 1);
    chk("stall_head_addr", waddr, 12);
    step();
    chk("stall_clear", alu_stall, 0);
    step();
    // slow write to r0 is popped without a register write
    set_slow(1, 5'd0, 32'h1234);
    step();
    set_slow(0, 0, 0);
    #1;
    chk("r0_we", we, 0);
    step();
    chk("r0_empty_ready", slow_ready, 1);
    chk("r0_drained_we", we, 0);
    // issue and commit to r7 in the same cycle
    issue_valid = 1; issue_rd = 5'd7; qaddr1 = 5'd7;
    step();
    issue_valid = 0; set_alu(1, 5'd4, 32'h44); set_slow(1, 5'd7, 32'h77);
    step();
    set_slow(0, 0, 0); set_alu(0, 0, 0); issue_valid = 1; issue_rd = 5'd7;
    #1;
    chk("r7_commit_we", we, 1);
    step();
    issue_valid = 0;
    #1;
    chk("r7_set_wins", busy1, 1);
    set_slow(1, 5'd7, 32'h78);
    step();
    set_slow(0, 0, 0);
    step();
    chk("r7_cleared", busy1, 0);
    // fill the FIFO and hold a third result until space frees
    set_alu(1, 5'd3, 32'h11);
    set_slow(1, 5'd21, 32'hA1);
    step();
    set_slow(1, 5'd22, 32'hA2);
    step();
    set_slow(1, 5'd20, 32'hAA);
    #1;
    chk("fill_ready", slow_ready, 0);
    step();
    set_alu(0, 0, 0);
    step();
    chk("fill_after_pop_ready", slow_ready, 1);
    chk("fill_second_addr", waddr, 22);
    step();
    chk("fill_held_taken", int'(last_push), 1);
    set_slow(0, 0, 0);
    #1;
    chk("fill_order_addr", waddr, 20);
    chk("fill_order_data", wdata, 32'hAA);
    step();
    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      alu_we = (starve != LIMIT) && ($urandom_range(1) == 1);
      alu_waddr = 5'($urandom);
      alu_wdata = $urandom;
      if (!slow_valid || last_push) begin
        slow_valid = $urandom_range(9) < 6;
        slow_waddr = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
        slow_wdata = $urandom;
      end
      issue_valid = $urandom_range(3) == 0;
      issue_rd = 5'($urandom);
      qaddr1 = 5'($urandom);
      qaddr2 = 5'($urandom);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
